// File: rtl/meter_arbiter.sv
// Parking-meter credit arbiter: sticky request latching, fixed-priority service,
// saturating count, state-dependent display blink. Optional sat flag: METER_SAT_FLAG_EN.
module meter_arbiter #(
  parameter int BLINK_DIV = 50000000,
  parameter int MAX_COUNT = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  add_req,
  input  logic [1:0]  load_req,
  input  logic        tick,
  output logic [15:0] count,
  output logic        blank,
  output logic [1:0]  mstate,
`ifdef METER_SAT_FLAG_EN
  output logic        sat,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_LOW     = 2'd1,
    ST_EXPIRED = 2'd2
  } mstate_e;

  localparam logic [16:0] MAX17   = 17'(MAX_COUNT);
  localparam logic [15:0] MAX16   = 16'(MAX_COUNT);
  localparam logic [31:0] LIM_EXP = 32'(BLINK_DIV - 1);
  localparam logic [31:0] LIM_LOW = 32'(2 * BLINK_DIV - 1);

  function automatic mstate_e f_state(input logic [15:0] c);
    mstate_e s;
    if (c == 16'd0)        s = ST_EXPIRED;
    else if (c < 16'd200)  s = ST_LOW;
    else                   s = ST_NORMAL;
    return s;
  endfunction

  function automatic logic [15:0] f_sat(input logic [16:0] s);
    return (s > MAX17) ? MAX16 : s[15:0];
  endfunction

  logic [15:0] r_count;
  logic [6:0]  r_pend;
  logic        r_busy;
  logic        r_blank;
  logic [31:0] r_blink_cnt;

  logic [6:0]  w_in;
  logic [6:0]  w_grant;
  logic [6:0]  w_clr;
  logic [6:0]  w_pend_nxt;
  logic [15:0] w_amt;
  logic [16:0] w_sum;
  logic [15:0] w_count_nxt;
  mstate_e     w_mst;
  mstate_e     w_mst_nxt;
  logic [31:0] w_lim;

  // Pending bit order is the service priority: load0, load1, add0..add3, tick.
  assign w_in = {tick, add_req, load_req};

  always_comb begin
    w_grant     = '0;
    w_amt       = '0;
    w_count_nxt = r_count;
    if (r_pend[0]) begin
      w_grant[0]  = 1'b1;
      w_count_nxt = 16'd10;
    end else if (r_pend[1]) begin
      w_grant[1]  = 1'b1;
      w_count_nxt = 16'd205;
    end else if (r_pend[2]) begin
      w_grant[2] = 1'b1;
      w_amt      = 16'd10;
    end else if (r_pend[3]) begin
      w_grant[3] = 1'b1;
      w_amt      = 16'd180;
    end else if (r_pend[4]) begin
      w_grant[4] = 1'b1;
      w_amt      = 16'd200;
    end else if (r_pend[5]) begin
      w_grant[5] = 1'b1;
      w_amt      = 16'd550;
    end else if (r_pend[6]) begin
      w_grant[6] = 1'b1;
      if (r_count != 16'd0) w_count_nxt = r_count - 16'd1;
    end
    w_sum = {1'b0, r_count} + {1'b0, w_amt};
    if (|w_grant[5:2]) w_count_nxt = f_sat(w_sum);
    // A load flushes queued credits and ticks; the other load stays queued.
    w_clr = w_grant;
    if (|w_grant[1:0]) w_clr = w_clr | 7'b1111100;
    w_pend_nxt = (r_pend & ~w_clr) | w_in;
  end

  assign w_mst     = f_state(r_count);
  assign w_mst_nxt = f_state(w_count_nxt);
  assign w_lim     = (w_mst == ST_LOW) ? LIM_LOW : LIM_EXP;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count     <= '0;
      r_pend      <= '0;
      r_busy      <= 1'b0;
      r_blank     <= 1'b0;
      r_blink_cnt <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_pend  <= w_pend_nxt;
      r_busy  <= |w_pend_nxt;
      // Restart the blink phase on the same edge the state changes.
      if ((w_mst_nxt != w_mst) || (w_mst == ST_NORMAL)) begin
        r_blink_cnt <= '0;
        r_blank     <= 1'b0;
      end else if (r_blink_cnt == w_lim) begin
        r_blink_cnt <= '0;
        r_blank     <= ~r_blank;
      end else begin
        r_blink_cnt <= r_blink_cnt + 32'd1;
      end
    end
  end

`ifdef METER_SAT_FLAG_EN
  logic r_sat;
  logic w_clip;

  assign w_clip = (|w_grant[5:2]) && (w_sum > MAX17);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sat <= 1'b0;
    else       r_sat <= w_clip;
  end

  assign sat = r_sat;
`endif

  assign count  = r_count;
  assign blank  = r_blank;
  assign busy   = r_busy;
  assign mstate = w_mst;

endmodule

// File: tb/tb_meter_arbiter.sv
// Directed self-checking bench for meter_arbiter (BLINK_DIV=4).
module tb_meter_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  add_req = '0;
  logic [1:0]  load_req = '0;
  logic        tick = 1'b0;
  logic [15:0] count;
  logic        blank;
  logic [1:0]  mstate;
  logic        busy;
`ifdef METER_SAT_FLAG_EN
  logic        sat;
`endif

  int tests = 0;
  int fails = 0;

  meter_arbiter #(.BLINK_DIV(4), .MAX_COUNT(9999)) dut (
    .clk(clk),
    .reset(reset),
    .add_req(add_req),
    .load_req(load_req),
    .tick(tick),
    .count(count),
    .blank(blank),
    .mstate(mstate),
`ifdef METER_SAT_FLAG_EN
    .sat(sat),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] a, input logic [1:0] l, input logic t);
    add_req = a; load_req = l; tick = t;
    cyc();
    add_req = '0; load_req = '0; tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    reset = 1'b1;
    #1;
    tests++; if (count !== 16'd0) begin fails++; $display("FAIL rst_count got %0d exp 0", count); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %0b exp 0", busy); end
    tests++; if (blank !== 1'b0) begin fails++; $display("FAIL rst_blank got %0b exp 0", blank); end
    tests++; if (mstate !== 2'd2) begin fails++; $display("FAIL rst_mstate got %0d exp 2", mstate); end
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_single_add();
    do_reset();
    pulse(4'b0001, 2'b00, 1'b0);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_hi got %0b exp 1", busy); end
    cyc();
    tests++; if (count !== 16'd10) begin fails++; $display("FAIL single_count got %0d exp 10", count); end
    tests++; if (mstate !== 2'd1) begin fails++; $display("FAIL single_mstate got %0d exp 1", mstate); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_lo got %0b exp 0", busy); end
  endtask

  task automatic test_all_adds();
    logic [15:0] exp_c [4] = '{16'd10, 16'd190, 16'd390, 16'd940};
    do_reset();
    pulse(4'b1111, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      tests++;
      if (count !== exp_c[i]) begin
        fails++; $display("FAIL all_adds_%0d got %0d exp %0d", i, count, exp_c[i]);
      end
    end
    tests++; if (mstate !== 2'd0) begin fails++; $display("FAIL all_adds_mstate got %0d exp 0", mstate); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL all_adds_busy got %0b exp 0", busy); end
  endtask

  task automatic test_merge();
    do_reset();
    add_req = 4'b0011;
    cyc();
    add_req = 4'b0010;
    cyc();
    add_req = 4'b0000;
    tests++; if (count !== 16'd10) begin fails++; $display("FAIL merge_c1 got %0d exp 10", count); end
    cyc();
    tests++; if (count !== 16'd190) begin fails++; $display("FAIL merge_c2 got %0d exp 190", count); end
    cyc();
    tests++; if (count !== 16'd190) begin fails++; $display("FAIL merge_c3 got %0d exp 190", count); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL merge_busy got %0b exp 0", busy); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 18; i++) begin
      pulse(4'b1000, 2'b00, 1'b0);
      cyc();
    end
    tests++; if (count !== 16'd9900) begin fails++; $display("FAIL sat_pre got %0d exp 9900", count); end
    pulse(4'b1000, 2'b00, 1'b0);
    cyc();
    tests++; if (count !== 16'd9999) begin fails++; $display("FAIL sat_count got %0d exp 9999", count); end
`ifdef METER_SAT_FLAG_EN
    tests++; if (sat !== 1'b1) begin fails++; $display("FAIL sat_flag_hi got %0b exp 1", sat); end
    cyc();
    tests++; if (sat !== 1'b0) begin fails++; $display("FAIL sat_flag_lo got %0b exp 0", sat); end
`endif
    pulse(4'b0001, 2'b00, 1'b0);
    cyc();
    tests++; if (count !== 16'd9999) begin fails++; $display("FAIL sat_hold got %0d exp 9999", count); end
  endtask

  task automatic test_load_priority();
    do_reset();
    pulse(4'b0000, 2'b10, 1'b0);
    cyc();
    tests++; if (count !== 16'd205) begin fails++; $display("FAIL load1 got %0d exp 205", count); end
    pulse(4'b0100, 2'b01, 1'b1);
    cyc();
    tests++; if (count !== 16'd10) begin fails++; $display("FAIL load0 got %0d exp 10", count); end
    cyc();
    tests++; if (count !== 16'd10) begin fails++; $display("FAIL load_flush got %0d exp 10", count); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL load_busy got %0b exp 0", busy); end
  endtask

  task automatic test_tick_expire();
    logic exp_b;
    do_reset();
    pulse(4'b0000, 2'b01, 1'b0);
    cyc();
    for (int i = 0; i < 9; i++) begin
      pulse(4'b0000, 2'b00, 1'b1);
      cyc();
    end
    tests++; if (count !== 16'd1) begin fails++; $display("FAIL tick_one got %0d exp 1", count); end
    pulse(4'b0000, 2'b00, 1'b1);
    cyc();
    tests++; if (count !== 16'd0) begin fails++; $display("FAIL tick_zero got %0d exp 0", count); end
    tests++; if (mstate !== 2'd2) begin fails++; $display("FAIL tick_mstate got %0d exp 2", mstate); end
    tests++; if (blank !== 1'b0) begin fails++; $display("FAIL tick_blank0 got %0b exp 0", blank); end
    for (int k = 1; k <= 8; k++) begin
      cyc();
      exp_b = (k >= 4 && k < 8);
      tests++;
      if (blank !== exp_b) begin
        fails++; $display("FAIL exp_blink_%0d got %0b exp %0b", k, blank, exp_b);
      end
    end
    pulse(4'b0000, 2'b00, 1'b1);
    cyc();
    tests++; if (count !== 16'd0) begin fails++; $display("FAIL tick_floor got %0d exp 0", count); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL tick_busy got %0b exp 0", busy); end
  endtask

  task automatic test_low_blink_reset();
    logic b;
    int   n;
    bit   seen;
    do_reset();
    pulse(4'b0000, 2'b01, 1'b0);
    cyc();
    for (int i = 0; i < 14; i++) begin
      pulse(4'b0001, 2'b00, 1'b0);
      cyc();
    end
    tests++; if (count !== 16'd150) begin fails++; $display("FAIL low_count got %0d exp 150", count); end
    tests++; if (mstate !== 2'd1) begin fails++; $display("FAIL low_mstate got %0d exp 1", mstate); end
    b = blank; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin cyc(); if (blank !== b) seen = 1; end
    b = blank; n = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin cyc(); n++; if (blank !== b) seen = 1; end
    tests++; if (!seen || n != 8) begin fails++; $display("FAIL low_period got %0d exp 8", n); end
    pulse(4'b0001, 2'b00, 1'b0);
    add_req = 4'b0001;
    #1;
    reset = 1'b1;
    #1;
    tests++; if (count !== 16'd0) begin fails++; $display("FAIL arst_count got %0d exp 0", count); end
    tests++; if (blank !== 1'b0) begin fails++; $display("FAIL arst_blank got %0b exp 0", blank); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL arst_busy got %0b exp 0", busy); end
    cyc();
    reset = 1'b0;
    add_req = 4'b0000;
    cyc();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_discard_busy got %0b exp 0", busy); end
    tests++; if (count !== 16'd0) begin fails++; $display("FAIL rst_discard_count got %0d exp 0", count); end
    pulse(4'b0001, 2'b00, 1'b0);
    cyc();
    tests++; if (count !== 16'd10) begin fails++; $display("FAIL post_rst_add got %0d exp 10", count); end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_single_add();
    test_all_adds();
    test_merge();
    test_saturate();
    test_load_priority();
    test_tick_expire();
    test_low_blink_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
